// File: rtl/load_align_queue_pkg.sv
// Shared types for the in-order load-result unit: load type encoding, size and
// left/right merge encodings, and the per-entry queue metadata.
// Latency: n/a (types only). Backpressure: n/a.
package load_align_queue_pkg;

    // Access size field of a load.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Partial-word merge selector (LWL / LWR).
    localparam logic [1:0] LR_NONE = 2'b00;
    localparam logic [1:0] LR_LWR  = 2'b01;
    localparam logic [1:0] LR_LWL  = 2'b10;

    // Widest byte offset the unit supports (DATA_W = 64).
    localparam int MAX_OFF_W = 3;

    typedef struct packed {
        logic       sgn;
        logic [1:0] size;
        logic [1:0] lr;
    } LoadType;

    // Width-independent part of a queue entry. The rt value and the tag are
    // parameter-sized and live in side arrays indexed by the same pointer.
    typedef struct packed {
        LoadType                ltype;
        logic [MAX_OFF_W-1:0]   offset;
        logic                   kill;
    } entry_t;

endpackage

// File: rtl/load_align_queue_if.sv
// Handshake bundle between MEM1 request, D-cache response and MEM2 writeback.
// Latency: n/a (wires only). Backpressure: req_ready, rsp_ready, out_ready.
// slave = the load-result unit, master = the surrounding pipeline / cache.
interface load_align_queue_if
    import load_align_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) ();
    localparam int OFF_W = $clog2(DATA_W/8);

    logic              req_valid;
    logic              req_ready;
    LoadType           req_type;
    logic [OFF_W-1:0]  req_offset;
    logic [DATA_W-1:0] req_rt;
    logic [TAG_W-1:0]  req_tag;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output req_valid, req_type, req_offset, req_rt, req_tag, flush,
               rsp_valid, rsp_data, out_ready,
        input  req_ready, rsp_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  req_valid, req_type, req_offset, req_rt, req_tag, flush,
               rsp_valid, rsp_data, out_ready,
        output req_ready, rsp_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/load_load_lane_align_note.sv
// Lane extraction, sign/zero extension and LWL/LWR merge for one load.
// Latency: combinational. Backpressure: none.
// Ports: ltype/offset/mem (+rt with LOAD_UNALIGNED_EN) in, result out.
module load_lane_align
    import load_align_queue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  LoadType                          ltype,
    input  logic [$clog2(DATA_W/8)-1:0]      offset,
`ifdef LOAD_UNALIGNED_EN
    input  logic [31:0]                      rt,
`endif
    input  logic [DATA_W-1:0]                mem,
    output logic [DATA_W-1:0]                result
);
    localparam int OFF_W = $clog2(DATA_W/8);

    logic [31:0] word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // 32-bit word holding the addressed bytes; the top offset bit picks it on 64.
    generate
        if (DATA_W == 64) begin : g_w64
            assign word = offset[OFF_W-1] ? mem[DATA_W-1 -: 32] : mem[31:0];
        end else begin : g_w32
            assign word = mem[31:0];
        end
    endgenerate

    // Misaligned offsets are rounded down to the natural lane.
    assign byte_lane = word[8*offset[1:0] +: 8];
    assign half_lane = word[16*offset[1] +: 16];

`ifdef LOAD_UNALIGNED_EN
    logic [31:0] lwl;
    logic [31:0] lwr;

    always_comb begin
        lwl = word;
        lwr = word;
        case (offset[1:0])
            2'd0: begin lwl = {word[7:0],  rt[23:0]}; lwr = word;                        end
            2'd1: begin lwl = {word[15:0], rt[15:0]}; lwr = {rt[31:24], word[31:8]};     end
            2'd2: begin lwl = {word[23:0], rt[7:0]};  lwr = {rt[31:16], word[31:16]};    end
            default: begin lwl = word;                lwr = {rt[31:8],  word[31:24]};    end
        endcase
    end
`else
    // Merge selector has no effect without the unaligned feature.
    logic unused_lr;
    assign unused_lr = ^ltype.lr;
`endif

    always_comb begin
        result = '0;
        case (ltype.size)
            SIZE_B: begin
                if (ltype.sgn) result = DATA_W'($signed(byte_lane));
                else           result = DATA_W'(byte_lane);
            end
            SIZE_H: begin
                if (ltype.sgn) result = DATA_W'($signed(half_lane));
                else           result = DATA_W'(half_lane);
            end
            SIZE_W: begin
                if (ltype.sgn) result = DATA_W'($signed(word));
                else           result = DATA_W'(word);
            end
            default: begin
                // Dword only exists on a 64-bit datapath.
                result = (DATA_W == 64) ? mem : 'x;
            end
        endcase
`ifdef LOAD_UNALIGNED_EN
        if (ltype.lr == LR_LWL) result = DATA_W'($signed(lwl));
        if (ltype.lr == LR_LWR) result = DATA_W'($signed(lwr));
`endif
    end
endmodule

// File: rtl/load_align_queue.sv
// In-order load-result queue: pairs D-cache responses with issued load metadata.
// Latency: response accepted in cycle N -> out_valid in N+1.
// Backpressure: req_ready low when full or flushing; rsp_ready low while the
// output register is stalled and the head load is live. Optional feature macro:
// LOAD_UNALIGNED_EN (LWL/LWR merge, stores rt per entry).
// Ports: clk, rst (async high), bus (load_align_queue_if.slave).
module load_align_queue
    import load_align_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    load_align_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(DATA_W/8);

    entry_t             meta_q [DEPTH];
    logic [TAG_W-1:0]   tag_q  [DEPTH];
`ifdef LOAD_UNALIGNED_EN
    logic [31:0]        rt_q   [DEPTH];
`endif
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [TAG_W-1:0]   out_tag_q;

    entry_t             head;
    logic [DATA_W-1:0]  align_res;
    logic               push;
    logic               pop;
    logic               unused_head_off;

    assign head = meta_q[rd_ptr];
    assign unused_head_off = ^head.offset;

    assign bus.req_ready = (count != CNT_W'(DEPTH)) && !bus.flush;
    // A killed head never produces output, so it may drain through a stall.
    assign bus.rsp_ready = (count != '0) && (head.kill || !out_valid_q || bus.out_ready);

    assign push = bus.req_valid && bus.req_ready;
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;

    load_lane_align #(.DATA_W(DATA_W)) u_align (
        .ltype  (head.ltype),
        .offset (head.offset[OFF_W-1:0]),
`ifdef LOAD_UNALIGNED_EN
        .rt     (rt_q[rd_ptr]),
`endif
        .mem    (bus.rsp_data),
        .result (align_res)
    );

    // Payload side arrays need no reset: they are only read behind a valid entry.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr] <= bus.req_tag;
`ifdef LOAD_UNALIGNED_EN
            rt_q[wr_ptr]  <= bus.req_rt[31:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            for (int i = 0; i < DEPTH; i++) meta_q[i] <= '0;
        end else begin
            // Marking empty slots too is harmless: a push rewrites kill to 0,
            // and push cannot coincide with flush.
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) meta_q[i].kill <= 1'b1;
            end
            if (push) begin
                meta_q[wr_ptr] <= '{ltype:  bus.req_type,
                                    offset: MAX_OFF_W'(bus.req_offset),
                                    kill:   1'b0};
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);

            // A response in the flush cycle is treated as killed.
            if (pop && !head.kill && !bus.flush) begin
                out_valid_q <= 1'b1;
                out_data_q  <= align_res;
                out_tag_q   <= tag_q[rd_ptr];
            end else if (bus.flush || (out_valid_q && bus.out_ready)) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_align_queue.sv
// Self-checking bench for load_align_queue: queue-based reference model with a
// per-cycle compare process, directed cases with literal expectations, and
// randomized traffic including flushes and output stalls.
module tb_load_align_queue;
    import load_align_queue_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_align_queue_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    load_align_queue #(.DATA_W(DW), .DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 64-bit lane aligner exercised directly with literal cases.
    LoadType     l64_type;
    logic [2:0]  l64_off;
    logic [31:0] l64_rt;
    logic [63:0] l64_mem;
    logic [63:0] l64_res;

    load_lane_align #(.DATA_W(64)) u_lane64 (
        .ltype  (l64_type),
        .offset (l64_off),
`ifdef LOAD_UNALIGNED_EN
        .rt     (l64_rt),
`endif
        .mem    (l64_mem),
        .result (l64_res)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic LoadType lt(logic s, logic [1:0] sz, logic [1:0] lr);
        LoadType r;
        r.sgn  = s;
        r.size = sz;
        r.lr   = lr;
        return r;
    endfunction

    // Expected result straight from the load semantics, using shifts and masks.
    function automatic logic [31:0] model_result(LoadType t, logic [1:0] off,
                                                 logic [31:0] rt, logic [31:0] mem);
        int k;
        logic [31:0] v;
        k = int'(off);
`ifdef LOAD_UNALIGNED_EN
        if (t.lr == LR_LWL) return (mem << (8*(3-k))) | (rt & (32'hFFFF_FFFF >> (8*(k+1))));
        if (t.lr == LR_LWR) return (mem >> (8*k)) | (rt & ~(32'hFFFF_FFFF >> (8*k)));
`endif
        case (t.size)
            SIZE_B: begin
                v = (mem >> (8*k)) & 32'hFF;
                if (t.sgn && v[7]) v = v | 32'hFFFF_FF00;
            end
            SIZE_H: begin
                v = (mem >> (8*(k & 2))) & 32'hFFFF;
                if (t.sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = mem;
        endcase
        return v;
    endfunction

    typedef struct {
        LoadType          t;
        logic [1:0]       off;
        logic [31:0]      rt;
        logic [TW-1:0]    tag;
        bit               kill;
    } mentry_t;

    mentry_t       mq[$];
    bit            mov;
    logic [31:0]   mod;
    logic [TW-1:0] mot;
    int            cache_pending;
    int            fire_cnt;
    logic [TW-1:0] last_fire_tag;

    // Compare process: sample mid-cycle, check against model, then advance model.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mov = 0;
            cache_pending = 0;
        end else begin
            bit exp_rr, push, pop, ofire;
            mentry_t h, n;
            exp_rr = 0;
            if (mq.size() != 0) exp_rr = mq[0].kill || !mov || bus.out_ready;
            chk("req_ready", bus.req_ready, (mq.size() != DEPTH) && !bus.flush);
            chk("rsp_ready", bus.rsp_ready, exp_rr);
            chk("out_valid", bus.out_valid, mov);
            if (mov) begin
                chk("out_data", bus.out_data, mod);
                chk("out_tag", bus.out_tag, mot);
                checks++;
                assert (!$isunknown(bus.out_data)) else begin
                    errors++;
                    $display("FAIL out_data_known: got %h, expected no X", bus.out_data);
                end
            end
            push  = bus.req_valid && bus.req_ready;
            pop   = bus.rsp_valid && bus.rsp_ready;
            ofire = bus.out_valid && bus.out_ready;
            if (ofire) begin
                fire_cnt++;
                last_fire_tag = bus.out_tag;
            end
            if (push) cache_pending++;
            if (pop)  cache_pending--;
            if (ofire) mov = 0;
            if (pop && mq.size() != 0) begin
                h = mq.pop_front();
                if (!h.kill && !bus.flush) begin
                    mov = 1;
                    mod = model_result(h.t, h.off, h.rt, bus.rsp_data);
                    mot = h.tag;
                end
            end
            if (bus.flush) begin
                mov = 0;
                foreach (mq[i]) mq[i].kill = 1;
            end
            if (push) begin
                n.t = bus.req_type; n.off = bus.req_offset; n.rt = bus.req_rt;
                n.tag = bus.req_tag; n.kill = 0;
                mq.push_back(n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 0; bus.req_type = lt(0, SIZE_W, LR_NONE); bus.req_offset = '0;
        bus.req_rt = '0; bus.req_tag = '0; bus.flush = 0;
        bus.rsp_valid = 0; bus.rsp_data = '0; bus.out_ready = 1;
    endtask

    task automatic set_req(LoadType t, logic [1:0] off, logic [31:0] rt, logic [TW-1:0] tag);
        bus.req_valid = 1; bus.req_type = t; bus.req_offset = off;
        bus.req_rt = rt; bus.req_tag = tag;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        tick();
        tick();
        rst = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_ready", bus.rsp_ready, 0);
    endtask

    // Single load on an empty queue: push, respond next cycle, result one later.
    task automatic one_load(string name, LoadType t, logic [1:0] off, logic [31:0] rt,
                            logic [31:0] mem, logic [31:0] exp, logic [TW-1:0] tag);
        set_req(t, off, rt, tag);
        tick();
        bus.req_valid = 0;
        bus.rsp_valid = 1;
        bus.rsp_data  = mem;
        tick();
        bus.rsp_valid = 0;
        chk({name, "_vld"}, bus.out_valid, 1);
        chk(name, bus.out_data, exp);
        chk({name, "_tag"}, bus.out_tag, tag);
        tick();
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        bus.req_valid = 0;
        bus.out_ready = 1;
        bus.rsp_valid = (cache_pending > 0);
        while (cache_pending > 0 && n < 100) begin
            bus.rsp_data = $urandom;
            tick();
            n++;
            bus.rsp_valid = (cache_pending > 0);
        end
        bus.rsp_valid = 0;
        chk(name, cache_pending, 0);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] d0;
        idle();
        do_reset();

        // Extension cases, literal expectations.
        one_load("lb_off3",  lt(1, SIZE_B, LR_NONE), 2'd3, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80, 5'd1);
        one_load("lbu_off3", lt(0, SIZE_B, LR_NONE), 2'd3, 32'h0, 32'h80FF_1234, 32'h0000_0080, 5'd2);
        one_load("lh_off2",  lt(1, SIZE_H, LR_NONE), 2'd2, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 5'd3);
        one_load("lhu_off1", lt(0, SIZE_H, LR_NONE), 2'd1, 32'h0, 32'h80FF_9234, 32'h0000_9234, 5'd4);
`ifdef LOAD_UNALIGNED_EN
        one_load("lwl_off1", lt(0, SIZE_W, LR_LWL), 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 5'd5);
        one_load("lwr_off2", lt(0, SIZE_W, LR_LWR), 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 5'd6);
`else
        one_load("lwl_off1", lt(0, SIZE_W, LR_LWL), 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 5'd5);
        one_load("lwr_off2", lt(0, SIZE_W, LR_LWR), 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 5'd6);
`endif

        // 64-bit lane aligner.
        l64_rt = 32'h0; l64_mem = 64'h8000_0001_0000_0002;
        l64_type = lt(1, SIZE_W, LR_NONE); l64_off = 3'd4; #1;
        chk("lw64_off4", l64_res, 64'hFFFF_FFFF_8000_0001);
        l64_type = lt(0, SIZE_D, LR_NONE); l64_off = 3'd0; #1;
        chk("ld64", l64_res, 64'h8000_0001_0000_0002);
        l64_type = lt(0, SIZE_B, LR_NONE); l64_off = 3'd7; #1;
        chk("lbu64_off7", l64_res, 64'h0000_0000_0000_0080);

        // Fill to DEPTH, then simultaneous response and push at full.
        for (int i = 0; i < DEPTH; i++) begin
            set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, TW'(20 + i));
            tick();
        end
        chk("full_req_ready", bus.req_ready, 0);
        set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, 5'd30);
        bus.rsp_valid = 1; bus.rsp_data = 32'h1234_5678;
        tick();
        bus.rsp_valid = 0;
        chk("pop_at_full_out", bus.out_tag, 20);
        chk("pop_at_full_req_ready", bus.req_ready, 1);
        set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, 5'd31);
        tick();
        chk("refill_to_full", bus.req_ready, 0);
        drain("drain_full");

        // Flush with three pending, one new load behind them.
        for (int i = 0; i < 3; i++) begin
            set_req(lt(0, SIZE_B, LR_NONE), 2'(i), 32'h0, TW'(1 + i));
            tick();
        end
        bus.req_valid = 0; bus.flush = 1;
        tick();
        bus.flush = 0;
        set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, 5'd7);
        tick();
        bus.req_valid = 0;
        fire_cnt = 0;
        drain("drain_flush");
        chk("flush_one_output", fire_cnt, 1);
        chk("flush_output_tag", last_fire_tag, 7);

        // Output stall with two responses pending.
        set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, 5'd10); tick();
        set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, 5'd11); tick();
        bus.req_valid = 0; bus.out_ready = 0;
        bus.rsp_valid = 1; bus.rsp_data = 32'hCAFE_0001;
        tick();
        chk("stall_first_vld", bus.out_valid, 1);
        chk("stall_first_tag", bus.out_tag, 10);
        d0 = bus.out_data;
        bus.rsp_data = 32'hCAFE_0002;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_ready", bus.rsp_ready, 0);
            chk("stall_out_hold", bus.out_data, d0);
            tick();
        end
        bus.out_ready = 1;
        tick();
        bus.rsp_valid = 0;
        chk("release_second_vld", bus.out_valid, 1);
        chk("release_second_tag", bus.out_tag, 11);
        chk("release_second_data", bus.out_data, 32'hCAFE_0002);
        tick();
        chk("release_done", bus.out_valid, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_type   = lt(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                                2'($urandom_range(0, 2)));
            bus.req_offset = 2'($urandom);
            bus.req_rt     = $urandom;
            bus.req_tag    = TW'($urandom);
            bus.flush      = ($urandom_range(0, 31) == 0);
            bus.rsp_valid  = (cache_pending > 0) && ($urandom_range(0, 3) != 0);
            bus.rsp_data   = $urandom;
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        drain("drain_random");

        // Reset with loads still queued.
        set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, 5'd12); tick();
        set_req(lt(0, SIZE_W, LR_NONE), 2'd0, 32'h0, 5'd13); tick();
        do_reset();
        tick();
        chk("post_reset_rsp_ready", bus.rsp_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_align_queue.md
# load_align_queue

Parametrised in-order load-result unit between the MEM1 request stage and MEM2 writeback. It captures per-load metadata (load type, byte offset, old rt, destination tag) into a DEPTH-entry queue when the D-cache request issues, pairs each in-order cache response with its metadata, and extracts, extends or merges the data. The result goes into a registered valid/ready output stage. It supports multiple outstanding loads, DATA_W of 32 or 64, and flush with drain of in-flight responses.

## Interface
- DATA_W, 32, datapath width; only 32 or 64 are legal
- DEPTH, 4, outstanding-load capacity; power of 2, ≥2
- TAG_W, 5, destination tag width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  load issued to D-cache this cycle
- req_ready  out  1  queue can accept metadata
- req_type  in  LoadType  sign, size (0 byte, 1 half, 2 word, 3 dword), LeftOrRight (10 LWL, 01 LWR, 00 normal)
- req_offset  in  $clog2(DATA_W/8)  address low bits
- req_rt  in  DATA_W  current rt value, used for LWL/LWR merge
- req_tag  in  TAG_W  destination tag
- flush  in  1  kill all pending loads
- rsp_valid  in  1  cache read data valid; in order, one per accepted request
- rsp_ready  out  1  unit consumes the response this cycle
- rsp_data  in  DATA_W  cache line word containing the addressed bytes
- out_valid  out  1  aligned result valid
- out_ready  in  1  writeback accepts result
- out_data  out  DATA_W  aligned, extended or merged result
- out_tag  out  TAG_W  destination tag of out_data

## Operation
- Queue: circular buffer with wr_ptr, rd_ptr and count (width $clog2(DEPTH)+1). Each entry holds type, offset, rt, tag and a kill bit.
- Push when req_valid && req_ready. req_ready = (count != DEPTH) && !flush. There is no pop-bypass when full.
- rsp_ready = (count != 0) && (head.kill || !out_valid || out_ready). A response handshake pops the head.
- Head not killed: the aligned result loads into the output register. Head killed: the response is discarded and no output is produced.
- Byte, half and word loads select the lane by offset, then sign- or zero-extend to DATA_W. Dword (DATA_W=64 only) passes rsp_data through. Size 3 with DATA_W=32 gives out_data all-X, which the bench flags via assertion.
- LWL/LWR: operate on the 32-bit word selected by offset[2] when DATA_W=64. Merge rule by offset[1:0]:
  - LWL 00 = {mem[7:0], rt[23:0]}
  - LWR 01 = {rt[31:24], mem[31:8]}
  - remaining offsets follow the same byte-merge rule
  - for DATA_W=64 the result is sign-extended from bit 31
- Misaligned normal loads (half at odd offset, word at offset[1:0]≠0, dword at offset≠0) are not checked here. Data is taken from the lane of offset rounded down.
- Flush:
  - sets kill on every valid entry
  - clears out_valid
  - blocks push in that cycle
  - a response arriving in the flush cycle is consumed as killed
- Killed entries drain as their responses arrive. Requests accepted after the flush are queued behind them and behave normally.

## Timing
- Reset values: count=0, pointers=0, all kill bits=0, out_valid=0, out_data=0, out_tag=0. After reset req_ready=1 and rsp_ready=0.
- Latency: a response accepted in cycle N gives out_valid in N+1.
- An entry pushed in cycle N is head-visible in N+1, so the earliest response is N+1.
- Push and pop in the same cycle: count unchanged; legal even when the queue is full, but only the pop occurs at full because req_ready=0.
- out stall (out_valid && !out_ready) with a non-killed head: rsp_ready=0 and out_data/out_tag hold.
- Reset mid-operation discards all entries. The cache side must be reset in the same cycle.

## Configuration
- LOAD_UNALIGNED_EN defined: LWL/LWR merge is implemented and req_rt is stored per entry.
- LOAD_UNALIGNED_EN undefined: rt storage is removed, req_rt is ignored, and LeftOrRight≠00 is treated as a normal load of the given size.

## Structure
- Shared package holds:
  - LoadType
  - size encodings (SIZE_B/H/W/D)
  - LeftOrRight encodings
  - the queue entry struct
- Sub-module load_lane_align: purely combinational (type, offset, rt, mem) → result, parametrised by DATA_W. It is instantiated once at the queue head.

## Test plan
- DATA_W=32, LB at offset 3, rsp_data=0x80FF_1234 → out_data=0xFFFF_FF80. The same case as LBU → 0x0000_0080.
- LWL at offset 1, rt=0xAABB_CCDD, mem=0x1122_3344 → 0x3344_CCDD. LWR at offset 2 with the same values → 0xAABB_1122.
- DATA_W=64, LW at offset 4, mem=0x8000_0001_0000_0002 → 0xFFFF_FFFF_8000_0001. LD → mem unchanged.
- Push DEPTH loads with no responses → req_ready=0 on the 4th accept. Then a response and a push in the same cycle → only the pop occurs and count=3.
- 3 pending loads, flush, then push 1 new load (tag 7). Send 4 responses → exactly one out_valid, with out_tag=7.
- Hold out_ready=0 for 5 cycles with 2 responses pending → rsp_ready=0 and out_data stable. Release → results in order, one per cycle.
